// File: rtl/ps2_pkg.sv
// PS/2 keyboard receiver shared definitions.
// Holds the frame FSM state type, frame geometry and the parity check.
package ps2_pkg;

  localparam int FRAME_LEN = 11;
  localparam int DATA_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_ok(
    input logic [DATA_W-1:0] d,
    input logic              p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus glitch filter for one raw PS/2 line.
// Ports: clk, rst_n, line_i (raw), level_o (filtered), fall_o (1->0 pulse).
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(FILTER_LEN - 1);

  logic          meta_q, sync_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= line_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  // The level flips on the FILTER_LEN-th consecutive differing sample;
  // any agreeing sample restarts the run.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    fall_d  = 1'b0;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TOP) begin
      cnt_d   = '0;
      level_d = sync_q;
      fall_d  = level_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard frame receiver with glitch filter and watchdog.
// Ports: clk, reset_n_i, ps2_clk_i, ps2_data_i -> code_o, strobe_o, err_o.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              ps2_clk_i,
  input  logic              ps2_data_i,
  output logic [DATA_W-1:0] ps2_kbd_code_o,
  output logic              ps2_kbd_strobe_o,
  output logic              ps2_kbd_err_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  logic clk_lvl, clk_fall, bit_ev;
  logic dmeta_q, din_q;

  ps2_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [DATA_W-1:0] code_q, code_d;
  logic              strobe_q, strobe_d;
  logic              err_q, err_d;
  logic              timeout;
  logic              stop_ev, frame_ok, start_bad;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filt (
    .clk    (clk),
    .rst_n  (reset_n_i),
    .line_i (ps2_clk_i),
    .level_o(clk_lvl),
    .fall_o (clk_fall)
  );

  assign bit_ev = clk_fall & ~clk_lvl;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dmeta_q  <= 1'b1;
      din_q    <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      wd_q     <= '0;
      code_q   <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      dmeta_q  <= ps2_data_i;
      din_q    <= dmeta_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      wd_q     <= wd_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  // A bit event in the same cycle as expiry wins over the timeout.
  assign timeout = (state_q != IDLE) && (wd_q == WD_MAX) && !bit_ev;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    unique case (state_q)
      IDLE: begin
        if (bit_ev && !din_q) begin
          state_d = DATA;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      DATA: begin
        if (bit_ev) begin
          shift_d[cnt_q] = din_q;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (bit_ev) begin
          par_d   = din_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_ev) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
    if (state_q == IDLE || bit_ev) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = wd_q;
    end
  end

  assign stop_ev   = bit_ev && (state_q == STOP);
  assign frame_ok  = din_q && odd_ok(shift_q, par_q);
  assign start_bad = bit_ev && (state_q == IDLE) && din_q;

  always_comb begin
    strobe_d = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    unique case (1'b1)
      timeout:              err_d = 1'b1;
      stop_ev && frame_ok: begin
        strobe_d = 1'b1;
        code_d   = shift_q;
      end
      stop_ev && !frame_ok: err_d = 1'b1;
      start_bad:            err_d = 1'b1;
      default: ;
    endcase
  end

  assign ps2_kbd_code_o   = code_q;
  assign ps2_kbd_strobe_o = strobe_q;
  assign ps2_kbd_err_o    = err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx with an expected-event scoreboard.
// Frames are pushed as expectations and matched against strobe/err pulses.
module tb_ps2_kbd_rx;

  logic       clk = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_data_i = 1'b1;
  logic [7:0] ps2_kbd_code_o;
  logic       ps2_kbd_strobe_o;
  logic       ps2_kbd_err_o;

  always #5 clk = ~clk;

  ps2_kbd_rx dut (
    .clk             (clk),
    .reset_n_i       (reset_n_i),
    .ps2_clk_i       (ps2_clk_i),
    .ps2_data_i      (ps2_data_i),
    .ps2_kbd_code_o  (ps2_kbd_code_o),
    .ps2_kbd_strobe_o(ps2_kbd_strobe_o),
    .ps2_kbd_err_o   (ps2_kbd_err_o)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] code;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] code_m = 8'h00;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n_i && (ps2_kbd_strobe_o || ps2_kbd_err_o)) begin
      exp_t e;
      chk("excl", 32'(ps2_kbd_strobe_o & ps2_kbd_err_o), 0);
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("kind_err", 32'(ps2_kbd_err_o), 32'(e.is_err));
        if (!e.is_err) chk("code", 32'(ps2_kbd_code_o), 32'(e.code));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n,
                           input int half, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data_i = bits[i];
      if (glitch && i == 4) begin
        cyc(10);
        ps2_clk_i = 1'b0;
        cyc(3);
        ps2_clk_i = 1'b1;
        cyc(half - 13);
      end else begin
        cyc(half);
      end
      ps2_clk_i = 1'b0;
      cyc(half);
      ps2_clk_i = 1'b1;
    end
    ps2_data_i = 1'b1;
    cyc(half);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par,
                            input bit stop, input int half,
                            input bit glitch, input string tag);
    logic       par;
    logic [10:0] bits;
    exp_t       e;
    par  = ~(^d) ^ bad_par;
    bits = {stop, par, d, 1'b0};
    if (stop && !bad_par) begin
      e.is_err = 1'b0;
      e.code   = d;
      code_m   = d;
    end else begin
      e.is_err = 1'b1;
      e.code   = 8'h00;
    end
    sb.push_back(e);
    send_bits(bits, 11, half, glitch);
    cyc(30);
    chk({tag, "_drain"}, 32'(sb.size()), 0);
    chk({tag, "_code"}, 32'(ps2_kbd_code_o), 32'(code_m));
  endtask

  initial begin
    exp_t e;
    cyc(5);
    chk("rst_code", 32'(ps2_kbd_code_o), 0);
    chk("rst_strobe", 32'(ps2_kbd_strobe_o), 0);
    chk("rst_err", 32'(ps2_kbd_err_o), 0);
    reset_n_i = 1'b1;
    cyc(20);

    send_frame(8'h1C, 1'b0, 1'b1, 500, 1'b0, "f1c");
    send_frame(8'hF0, 1'b0, 1'b1, 50, 1'b0, "ff0");
    send_frame(8'h1C, 1'b0, 1'b1, 50, 1'b0, "b2b");
    send_frame(8'h1C, 1'b1, 1'b1, 50, 1'b0, "badpar");
    send_frame(8'h1C, 1'b0, 1'b0, 50, 1'b0, "badstop");

    e.is_err = 1'b1;
    e.code   = 8'h00;
    sb.push_back(e);
    send_bits(11'b110_0011_1000, 4, 50, 1'b0);
    for (int i = 0; i < 52000 && sb.size() > 0; i++) cyc(1);
    chk("timeout_drain", 32'(sb.size()), 0);
    chk("timeout_code", 32'(ps2_kbd_code_o), 32'(code_m));
    sb.delete();
    send_frame(8'h5A, 1'b0, 1'b1, 50, 1'b0, "after_to");

    send_frame(8'h5A, 1'b0, 1'b1, 50, 1'b1, "glitch");

    send_bits({1'b1, 1'b1, 8'h77, 1'b0}, 5, 50, 1'b0);
    reset_n_i = 1'b0;
    code_m    = 8'h00;
    cyc(3);
    chk("mid_rst_code", 32'(ps2_kbd_code_o), 0);
    chk("mid_rst_strobe", 32'(ps2_kbd_strobe_o), 0);
    chk("mid_rst_err", 32'(ps2_kbd_err_o), 0);
    reset_n_i = 1'b1;
    cyc(200);
    chk("post_rst_code", 32'(ps2_kbd_code_o), 0);
    send_frame(8'h29, 1'b0, 1'b1, 50, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal synchronized ps2_clk samples required to accept a level change.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle clk cycles mid-frame before abort (2 ms at 25 MHz).
REQ-003 SHALL have port clk, input, 1: sole clock, rising-edge.
REQ-004 SHALL have port reset_n_i, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk_i, input, 1: raw PS/2 clock line, asynchronous.
REQ-006 SHALL have port ps2_data_i, input, 1: raw PS/2 data line, asynchronous.
REQ-007 SHALL have port ps2_kbd_code_o, output, 8: last correctly received scan-code byte.
REQ-008 SHALL have port ps2_kbd_strobe_o, output, 1: one-cycle pulse, new valid code.
REQ-009 SHALL have port ps2_kbd_err_o, output, 1: one-cycle pulse, frame error or timeout.

Function
REQ-010 SHALL pass ps2_clk_i and ps2_data_i through 2-FF synchronizers before any use.
REQ-011 SHALL change filtered clock level only after FILTER_LEN consecutive synchronized samples differ from the current filtered level; filtered level resets to 1.
REQ-012 SHALL treat a 1->0 transition of the filtered clock as a bit event and sample synchronized data in that same cycle.
REQ-013 SHALL receive 11-bit frames: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-014 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on bit event with data 0 -> DATA, bit count 0; with data 1 -> err pulse, remain IDLE.
REQ-016 DATA: each bit event shifts data into bit[count]; after 8th bit -> PARITY.
REQ-017 PARITY: bit event stores parity bit -> STOP.
REQ-018 STOP: bit event -> IDLE; if stop bit is 1 and the XOR of 8 data bits plus parity is 1, update code and pulse strobe, else pulse err only.
REQ-019 Strobe/err SHALL assert in the cycle after the stop-bit event, for exactly one cycle; strobe and err never asserted together.
REQ-020 ps2_kbd_code_o SHALL change only with a strobe and hold otherwise, including across errors.
REQ-021 Watchdog counter SHALL clear on every bit event and in IDLE; in any non-IDLE state reaching TIMEOUT_CYCLES -> err pulse next cycle, -> IDLE, partial byte discarded.
REQ-022 Watchdog counter SHALL saturate; width ceil(log2(TIMEOUT_CYCLES+1)).
REQ-023 Bit event coincident with timeout SHALL take priority over timeout (counter clears, frame continues).
REQ-024 No backpressure: consumer samples code on the strobe; back-to-back frames produce one strobe each.

Reset
REQ-025 reset_n_i low SHALL asynchronously force state IDLE, code 0x00, strobe 0, err 0, bit count 0, watchdog 0, filtered clock 1, synchronizers 1.
REQ-026 Reset mid-frame SHALL discard the partial byte; no strobe or err pulse on release.
REQ-027 After release, next frame SHALL be received normally from its start bit.

Structure
REQ-028 Shared package ps2_pkg SHALL hold the state typedef (IDLE, DATA, PARITY, STOP), frame length 11, and data width 8.
REQ-029 Synchronizer plus glitch filter SHALL be sub-module ps2_line_filter (parameter FILTER_LEN; outputs filtered level and fall-event pulse), used for the clock line.
REQ-030 Implementation SHALL be 120-400 lines of RTL with no vendor primitives.

Verification
REQ-031 Frame 0x1C, parity 0, stop 1, PS/2 bit period 1000 clk -> one strobe, code 0x1C, no err.
REQ-032 Frame 0xF0, parity 1, then frame 0x1C immediately after -> two strobes, codes 0xF0 then 0x1C.
REQ-033 Frame 0x1C with parity 1 -> one err pulse, no strobe, code keeps previous value.
REQ-034 Frame 0x1C with stop bit 0 -> err pulse, no strobe.
REQ-035 Four bits sent, then clock idle for 50000 cycles -> err pulse; following frame 0x5A with parity 1 -> strobe, code 0x5A.
REQ-036 3-cycle low glitch on ps2_clk_i inside frame 0x5A -> no extra bit, code 0x5A; reset_n_i low mid-frame -> outputs zero, no pulses.
